// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DMEM_DEPTH  = 32;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  // Requester identities; the value doubles as the grant index.
  typedef enum logic {
    REQ_PIPE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_e;

  // One outstanding access waiting for its response cycle.
  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    write;
    logic    err;
  } pend_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus: two request channels in, one shared response bus out.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]             req_valid;
  logic [1:0]             req_write;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             req_ready;
  logic [1:0]             rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    last_i,
  output logic [1:0] gnt_o
);

  // Single requester passes straight through; contention resolved by last winner.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == REQ_DBG) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of the single-port data memory, with
// one-cycle response routing and out-of-range error reporting.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  req_id_e           last_grant_q, last_grant_d;
  pend_t             pend_q, pend_d;
  logic [1:0]        gnt;
  logic              accept;
  req_id_e           gnt_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              in_range;

  rr_arb2 u_rr_arb2 (
    .req_i  (bus.req_valid),
    .last_i (last_grant_q),
    .gnt_o  (gnt)
  );

  // Select the winning request; nothing is accepted while reset is held.
  always_comb begin
    accept    = (gnt != 2'b00) && !rst;
    gnt_id    = gnt[1] ? REQ_DBG : REQ_PIPE;
    sel_addr  = bus.req_addr[gnt_id];
    sel_wdata = bus.req_wdata[gnt_id];
    sel_write = bus.req_write[gnt_id];
    in_range  = (sel_addr < DEPTH_A);
    bus.req_ready = accept ? gnt : 2'b00;
  end

  // Issue to memory in the accept cycle; out-of-range accesses never strobe.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (accept && in_range) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      mem_read  = !sel_write;
      mem_write = sel_write;
    end
  end

  // Next-state for the round-robin pointer and the pending-response slot.
  always_comb begin
    last_grant_d = last_grant_q;
    pend_d       = '0;
    if (accept) begin
      last_grant_d = gnt_id;
      pend_d.valid = 1'b1;
      pend_d.id    = gnt_id;
      pend_d.write = sel_write;
      pend_d.err   = !in_range;
    end
  end

  // Registered arbitration/pending state; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_DBG;
      pend_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
    end
  end

  // Route the response to the requester recorded at accept; suppressed during reset.
  always_comb begin
    bus.rsp_valid = 2'b00;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    if (pend_q.valid && !rst) begin
      bus.rsp_valid[pend_q.id] = 1'b1;
      bus.rsp_err              = pend_q.err;
      if (!pend_q.err && !pend_q.write) begin
        bus.rsp_rdata = mem_rdata;
      end
    end
  end

endmodule
